q100_dtcm_arb: RTL and testbench
================================

Name: q100_dtcm_arb

Overview:
- Two-requester arbiter and sequencer for the single-ported DTCM.
- Shares the DTCM between the core load/store path (MEM stage) and a DMA/debug port.
- Core has fixed priority, with starvation protection for DMA.
- Tracks the 1-cycle DTCM read latency and routes read data back to the requester that issued the read.
- Generates the core stall when the core loses arbitration.

Parameters:
ADDR_W, `DTCM_ADDR_WIDTH, DTCM byte-address width
DATA_W, `DTCM_DATA_WIDTH, DTCM data width (32)
BANKS, `DTCM_BANK, byte lanes / write-enable bits (4)
STARVE_MAX, 4, consecutive denied DMA cycles before DMA is forced a grant (1..15)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
core_req_i  in  1  core access request (MEM stage, load or store)
core_we_i  in  BANKS  core byte write enables; all-zero means read
core_addr_i  in  ADDR_W  core address
core_wdata_i  in  DATA_W  core store data
core_gnt_o  out  1  core access issued this cycle (comb)
core_stall_o  out  1  core_req_i & ~core_gnt_o (comb)
core_rvalid_o  out  1  core read data valid
core_rdata_o  out  DATA_W  core read data
dma_req_i  in  1  DMA access request; held until granted
dma_we_i  in  BANKS  DMA byte write enables; all-zero means read
dma_addr_i  in  ADDR_W  DMA address
dma_wdata_i  in  DATA_W  DMA write data
dma_gnt_o  out  1  DMA access issued this cycle (comb)
dma_rvalid_o  out  1  DMA read data valid
dma_rdata_o  out  DATA_W  DMA read data
dtcm_rw_addr_o  out  ADDR_W  muxed address to DTCM
dtcm_wr_data_o  out  DATA_W  muxed write data
dtcm_rw_en_o  out  BANKS  muxed byte write enables (1 = write)
dtcm_rd_data_i  in  DATA_W  DTCM read data, valid 1 cycle after the read address

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous, active-high.
- Reset values:
  - state = CORE_PRI; starve_cnt = 0; rd_pend_q = 0; rd_owner_q = 0.
  - core_rvalid_o = 0, dma_rvalid_o = 0.
  - Grants are forced to 0 while rst = 1, so dtcm_rw_en_o = 0 and the core stalls if it requests.
- FSM states:
  - CORE_PRI: core_req_i wins whenever asserted; DMA is granted only if core_req_i = 0.
  - DMA_FORCE: dma_req_i wins. If dma_req_i drops, the core is granted normally.
- Transitions:
  - CORE_PRI -> DMA_FORCE when starve_cnt reaches STARVE_MAX at a clock edge.
  - DMA_FORCE -> CORE_PRI after exactly one DMA grant, or immediately when dma_req_i = 0.
- starve_cnt:
  - Increments each cycle dma_req_i & ~dma_gnt_o, saturating at STARVE_MAX.
  - Clears on a DMA grant or when dma_req_i = 0.
- Datapath muxing:
  - DTCM address, write data and write enables are taken from the granted requester.
  - With no grant: dtcm_rw_en_o = 0, address/data from the core port.
  - Idle cycles are harmless reads whose data is discarded.
- Grant timing:
  - Zero latency: the grant is combinational in the request cycle.
  - At most one grant per cycle; core_gnt_o & dma_gnt_o is never 1.
- Read return:
  - A granted access with we == 0 sets rd_pend_q = 1 and rd_owner_q = requester (0 core, 1 dma).
  - Next cycle, the owner's rvalid = 1 and its rdata = dtcm_rd_data_i.
  - The other requester's rvalid = 0; its rdata is don't-care and driven 0.
  - Writes produce no rvalid.
- Back-to-back operation: one access per cycle is sustained. A read in cycle N and a grant in cycle N+1 coexist; the return pipeline is one deep.
- Simultaneous requests:
  - CORE_PRI: core granted, core_stall_o = 0.
  - DMA_FORCE: DMA granted, core_stall_o = 1.
- Reset mid-operation: a pending read is dropped and no rvalid is issued the cycle after reset.
- No alignment checking: byte-lane selection is the requester's responsibility.

Decomposition:
- Package q100_dtcm_pkg:
  - typedef enum logic {CORE_PRI, DMA_FORCE} arb_state_t;
  - typedef enum logic {OWN_CORE, OWN_DMA} dtcm_owner_t;
  - localparam STARVE_W = 4.
- One natural sub-module, q100_dtcm_rd_track: the 1-deep read-owner pipeline and rvalid/rdata routing. Keep arbitration, FSM and counter in the top.

Test Plan:
- Reset: assert rst with core_req_i = 1 -> core_gnt_o = 0, core_stall_o = 1, dtcm_rw_en_o = 0. After release, state CORE_PRI.
- Core read: core read of 0x0010 with DTCM returning 0xDEADBEEF -> core_gnt_o = 1 in cycle N; cycle N+1 core_rvalid_o = 1, core_rdata_o = 0xDEADBEEF, dma_rvalid_o = 0.
- Conflict with starvation, STARVE_MAX = 4:
  - Stimulus: core_req_i held high; DMA write 0xCAFEF00D to 0x0020 with we = 4'b1111.
  - Response: core granted for 4 cycles; the DMA is granted in the 5th cycle with dtcm_rw_en_o = 4'b1111 and core_stall_o = 1; the core is granted again in the 6th cycle.
- Interleaved reads: core read of 0x0004 in cycle N, DMA read of 0x0008 in cycle N+1 -> core_rvalid_o in N+1 and dma_rvalid_o in N+2, each carrying its own address's data.
- Byte store: core store with we = 4'b0001, wdata = 0x000000AB, DMA idle -> dtcm_rw_en_o = 4'b0001, no rvalid next cycle, starve_cnt remains 0.
- Reset during read: rst asserted in the cycle after a granted core read -> core_rvalid_o stays 0.

Source files
------------

// File: rtl/q100_dtcm_arb_pkg.sv
// -----------------------------------------------------------------------------
// q100_dtcm_pkg
// Shared types and constants for the DTCM arbiter slice.
//   arb_state_t  : arbitration mode (core priority / forced DMA grant)
//   dtcm_owner_t : which requester owns an outstanding DTCM read
//   STARVE_W     : width of the DMA starvation counter
//   DTCM_*       : default bus geometry, overridable by the global DTCM macros
// -----------------------------------------------------------------------------
`ifndef DTCM_ADDR_WIDTH
`define DTCM_ADDR_WIDTH 16
`endif
`ifndef DTCM_DATA_WIDTH
`define DTCM_DATA_WIDTH 32
`endif
`ifndef DTCM_BANK
`define DTCM_BANK 4
`endif

package q100_dtcm_pkg;

  typedef enum logic {
    CORE_PRI  = 1'b0,
    DMA_FORCE = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_DMA  = 1'b1
  } dtcm_owner_t;

  localparam int STARVE_W    = 4;
  localparam int DTCM_ADDR_W = `DTCM_ADDR_WIDTH;
  localparam int DTCM_DATA_W = `DTCM_DATA_WIDTH;
  localparam int DTCM_BANKS  = `DTCM_BANK;

endpackage

// File: rtl/q100_dtcm_arb_if.sv
// -----------------------------------------------------------------------------
// q100_dtcm_arb_if
// Bundles the core port, the DMA/debug port and the DTCM macro port of the
// DTCM arbiter.
//   slave  : arbiter view (requests and DTCM read data in, grants/data out)
//   master : environment view (drives requests and DTCM read data)
// Signal names keep the arbiter-relative _i/_o suffixes.
// -----------------------------------------------------------------------------
interface q100_dtcm_arb_if #(
  parameter int ADDR_W = q100_dtcm_pkg::DTCM_ADDR_W,
  parameter int DATA_W = q100_dtcm_pkg::DTCM_DATA_W,
  parameter int BANKS  = q100_dtcm_pkg::DTCM_BANKS
);

  // Core load/store path (MEM stage)
  logic              core_req_i;
  logic [BANKS-1:0]  core_we_i;
  logic [ADDR_W-1:0] core_addr_i;
  logic [DATA_W-1:0] core_wdata_i;
  logic              core_gnt_o;
  logic              core_stall_o;
  logic              core_rvalid_o;
  logic [DATA_W-1:0] core_rdata_o;

  // DMA / debug port
  logic              dma_req_i;
  logic [BANKS-1:0]  dma_we_i;
  logic [ADDR_W-1:0] dma_addr_i;
  logic [DATA_W-1:0] dma_wdata_i;
  logic              dma_gnt_o;
  logic              dma_rvalid_o;
  logic [DATA_W-1:0] dma_rdata_o;

  // DTCM macro
  logic [ADDR_W-1:0] dtcm_rw_addr_o;
  logic [DATA_W-1:0] dtcm_wr_data_o;
  logic [BANKS-1:0]  dtcm_rw_en_o;
  logic [DATA_W-1:0] dtcm_rd_data_i;

  modport slave (
    input  core_req_i, core_we_i, core_addr_i, core_wdata_i,
    output core_gnt_o, core_stall_o, core_rvalid_o, core_rdata_o,
    input  dma_req_i, dma_we_i, dma_addr_i, dma_wdata_i,
    output dma_gnt_o, dma_rvalid_o, dma_rdata_o,
    output dtcm_rw_addr_o, dtcm_wr_data_o, dtcm_rw_en_o,
    input  dtcm_rd_data_i
  );

  modport master (
    output core_req_i, core_we_i, core_addr_i, core_wdata_i,
    input  core_gnt_o, core_stall_o, core_rvalid_o, core_rdata_o,
    output dma_req_i, dma_we_i, dma_addr_i, dma_wdata_i,
    input  dma_gnt_o, dma_rvalid_o, dma_rdata_o,
    input  dtcm_rw_addr_o, dtcm_wr_data_o, dtcm_rw_en_o,
    output dtcm_rd_data_i
  );

endinterface

// File: rtl/q100_dtcm_arb_rd_track.sv
// -----------------------------------------------------------------------------
// q100_dtcm_rd_track
// One-deep read return pipeline. Remembers whether the access issued this
// cycle was a read and who issued it, then steers the DTCM read data (valid
// one cycle later) to that requester only.
//   clk, rst          : clock, synchronous active-high reset
//   rd_issue_i        : a granted read is issued this cycle
//   rd_owner_i        : requester of that read
//   dtcm_rd_data_i    : DTCM read data (1-cycle latency)
//   core_rvalid_o/rdata_o, dma_rvalid_o/rdata_o : routed read return
// -----------------------------------------------------------------------------
module q100_dtcm_rd_track
  import q100_dtcm_pkg::*;
#(
  parameter int DATA_W = DTCM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_issue_i,
  input  dtcm_owner_t       rd_owner_i,
  input  logic [DATA_W-1:0] dtcm_rd_data_i,
  output logic              core_rvalid_o,
  output logic [DATA_W-1:0] core_rdata_o,
  output logic              dma_rvalid_o,
  output logic [DATA_W-1:0] dma_rdata_o
);

  logic        rd_pend_q, rd_pend_d;
  dtcm_owner_t rd_owner_q, rd_owner_d;

  // Issue is already forced low by the arbiter during reset.
  assign rd_pend_d  = rd_issue_i;
  assign rd_owner_d = rd_issue_i ? rd_owner_i : rd_owner_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= OWN_CORE;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // A read issued the cycle before reset is still pending while rst is high;
  // masking with rst drops it instead of returning it into the reset cycle.
  assign core_rvalid_o = rd_pend_q & ~rst & (rd_owner_q == OWN_CORE);
  assign dma_rvalid_o  = rd_pend_q & ~rst & (rd_owner_q == OWN_DMA);
  assign core_rdata_o  = core_rvalid_o ? dtcm_rd_data_i : '0;
  assign dma_rdata_o   = dma_rvalid_o  ? dtcm_rd_data_i : '0;

endmodule

// File: rtl/q100_dtcm_arb.sv
// -----------------------------------------------------------------------------
// q100_dtcm_arb
// Arbiter/sequencer for the single-ported DTCM shared by the core MEM stage
// and a DMA/debug port. The core has fixed priority; a DMA request denied
// STARVE_MAX consecutive cycles is forced through for one access. Grants are
// combinational (zero latency), at most one per cycle.
//   clk, rst : clock, synchronous active-high reset
//   bus      : q100_dtcm_arb_if.slave (core port, DMA port, DTCM port)
// -----------------------------------------------------------------------------
module q100_dtcm_arb
  import q100_dtcm_pkg::*;
#(
  parameter int ADDR_W     = DTCM_ADDR_W,
  parameter int DATA_W     = DTCM_DATA_W,
  parameter int BANKS      = DTCM_BANKS,
  parameter int STARVE_MAX = 4
) (
  input logic            clk,
  input logic            rst,
  q100_dtcm_arb_if.slave bus
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  arb_state_t          state_q, state_d;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

  logic              core_gnt, dma_gnt;
  logic [ADDR_W-1:0] mux_addr;
  logic [DATA_W-1:0] mux_wdata;
  logic [BANKS-1:0]  mux_en;
  logic              rd_issue;
  dtcm_owner_t       rd_owner;

  // Grant selection. The mode only decides who wins a conflict; a lone
  // requester is always served.
  // NOTE: combinational blocks assign a default to every output first so no
  // path leaves a variable unassigned, which would infer a latch.
  always_comb begin
    core_gnt = 1'b0;
    dma_gnt  = 1'b0;
    if (!rst) begin
      if (state_q == DMA_FORCE) begin
        dma_gnt  = bus.dma_req_i;
        core_gnt = bus.core_req_i & ~bus.dma_req_i;
      end else begin
        core_gnt = bus.core_req_i;
        dma_gnt  = bus.dma_req_i & ~bus.core_req_i;
      end
    end
  end

  // Starvation counter: counts consecutive denied DMA cycles, saturating.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.dma_req_i || dma_gnt) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q < STARVE_LIM) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // DMA_FORCE lasts for one DMA grant, or ends at once if the DMA withdraws;
  // in that state either condition holds every cycle, so it is one cycle long.
  always_comb begin
    state_d = state_q;
    if (state_q == CORE_PRI) begin
      if (starve_cnt_d == STARVE_LIM) state_d = DMA_FORCE;
    end else begin
      if (dma_gnt || !bus.dma_req_i) state_d = CORE_PRI;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CORE_PRI;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // DTCM port mux. With no grant the core address is presented with all
  // enables low, i.e. a harmless read whose data nobody claims.
  always_comb begin
    mux_addr  = bus.core_addr_i;
    mux_wdata = bus.core_wdata_i;
    mux_en    = '0;
    if (dma_gnt) begin
      mux_addr  = bus.dma_addr_i;
      mux_wdata = bus.dma_wdata_i;
      mux_en    = bus.dma_we_i;
    end else if (core_gnt) begin
      mux_en    = bus.core_we_i;
    end
  end

  assign rd_issue = (core_gnt & ~|bus.core_we_i) | (dma_gnt & ~|bus.dma_we_i);
  assign rd_owner = dma_gnt ? OWN_DMA : OWN_CORE;

  q100_dtcm_rd_track #(
    .DATA_W (DATA_W)
  ) u_rd_track (
    .clk            (clk),
    .rst            (rst),
    .rd_issue_i     (rd_issue),
    .rd_owner_i     (rd_owner),
    .dtcm_rd_data_i (bus.dtcm_rd_data_i),
    .core_rvalid_o  (bus.core_rvalid_o),
    .core_rdata_o   (bus.core_rdata_o),
    .dma_rvalid_o   (bus.dma_rvalid_o),
    .dma_rdata_o    (bus.dma_rdata_o)
  );

  assign bus.core_gnt_o     = core_gnt;
  assign bus.dma_gnt_o      = dma_gnt;
  assign bus.core_stall_o   = bus.core_req_i & ~core_gnt;
  assign bus.dtcm_rw_addr_o = mux_addr;
  assign bus.dtcm_wr_data_o = mux_wdata;
  assign bus.dtcm_rw_en_o   = mux_en;

endmodule

// File: tb/tb_q100_dtcm_arb.sv
// -----------------------------------------------------------------------------
// tb_q100_dtcm_arb
// Self-checking bench for q100_dtcm_arb. A behavioural DTCM sits on the
// memory port; a reference model decides who should win each cycle from the
// arbitration rules (core first, unless the DMA has already waited STARVE_MAX
// cycles) and keeps a shadow copy of memory to predict read data.
// Inputs change 1 time unit after the rising edge; outputs are compared on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_q100_dtcm_arb;
  import q100_dtcm_pkg::*;

  localparam int AW         = 16;
  localparam int DW         = 32;
  localparam int BK         = 4;
  localparam int STARVE_MAX = 4;
  localparam int WORDS      = 2 ** (AW - 2);

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  q100_dtcm_arb_if #(.ADDR_W(AW), .DATA_W(DW), .BANKS(BK)) bus ();

  q100_dtcm_arb #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .BANKS      (BK),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural single-port DTCM: byte-enabled write, registered read.
  bit [DW-1:0] tb_mem [WORDS];
  bit [DW-1:0] dtcm_rd_q;

  always @(posedge clk) begin
    for (int b = 0; b < BK; b++) begin
      if (bus.dtcm_rw_en_o[b]) tb_mem[bus.dtcm_rw_addr_o[AW-1:2]][8*b +: 8] <= bus.dtcm_wr_data_o[8*b +: 8];
    end
    dtcm_rd_q <= tb_mem[bus.dtcm_rw_addr_o[AW-1:2]];
  end

  assign bus.dtcm_rd_data_i = dtcm_rd_q;

  // Reference model state
  bit [DW-1:0] shadow [WORDS];
  int          dma_wait;
  bit          pend_v;
  bit          pend_dma;
  bit [DW-1:0] pend_data;

  // Last observed values, for directed step checks
  logic obs_core_gnt, obs_dma_gnt, obs_stall, obs_core_rv, obs_dma_rv;
  logic [DW-1:0] obs_core_rd, obs_dma_rd;
  logic [BK-1:0] obs_en;
  bit   e_dma_gnt_last;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: compare all outputs against the model, advance the model.
  task automatic cycle();
    bit          e_cg, e_dg, e_crv, e_drv;
    logic [AW-1:0] a;
    logic [BK-1:0] we;
    logic [DW-1:0] d;
    int unsigned   w;

    @(negedge clk);
    e_cg = 1'b0;
    e_dg = 1'b0;
    if (!rst) begin
      if (bus.dma_req_i && (dma_wait >= STARVE_MAX || !bus.core_req_i)) e_dg = 1'b1;
      else if (bus.core_req_i) e_cg = 1'b1;
    end
    e_crv = !rst && pend_v && !pend_dma;
    e_drv = !rst && pend_v && pend_dma;

    check("core_gnt", 32'(bus.core_gnt_o), 32'(e_cg));
    check("dma_gnt", 32'(bus.dma_gnt_o), 32'(e_dg));
    check("core_stall", 32'(bus.core_stall_o), 32'(bus.core_req_i && !e_cg));
    check("dtcm_addr", 32'(bus.dtcm_rw_addr_o), 32'(e_dg ? bus.dma_addr_i : bus.core_addr_i));
    check("dtcm_wdata", bus.dtcm_wr_data_o, e_dg ? bus.dma_wdata_i : bus.core_wdata_i);
    check("dtcm_en", 32'(bus.dtcm_rw_en_o), 32'(e_dg ? bus.dma_we_i : (e_cg ? bus.core_we_i : 4'b0)));
    check("core_rvalid", 32'(bus.core_rvalid_o), 32'(e_crv));
    check("dma_rvalid", 32'(bus.dma_rvalid_o), 32'(e_drv));
    check("core_rdata", bus.core_rdata_o, e_crv ? pend_data : 32'h0);
    check("dma_rdata", bus.dma_rdata_o, e_drv ? pend_data : 32'h0);

    obs_core_gnt = bus.core_gnt_o;
    obs_dma_gnt  = bus.dma_gnt_o;
    obs_stall    = bus.core_stall_o;
    obs_core_rv  = bus.core_rvalid_o;
    obs_dma_rv   = bus.dma_rvalid_o;
    obs_core_rd  = bus.core_rdata_o;
    obs_dma_rd   = bus.dma_rdata_o;
    obs_en       = bus.dtcm_rw_en_o;
    e_dma_gnt_last = e_dg;

    if (rst) begin
      pend_v   = 1'b0;
      dma_wait = 0;
    end else begin
      pend_v = 1'b0;
      if (e_cg || e_dg) begin
        a  = e_dg ? bus.dma_addr_i  : bus.core_addr_i;
        we = e_dg ? bus.dma_we_i    : bus.core_we_i;
        d  = e_dg ? bus.dma_wdata_i : bus.core_wdata_i;
        w  = a[AW-1:2];
        if (we == '0) begin
          pend_v    = 1'b1;
          pend_dma  = e_dg;
          pend_data = shadow[w];
        end else begin
          for (int b = 0; b < BK; b++) if (we[b]) shadow[w][8*b +: 8] = d[8*b +: 8];
        end
      end
      dma_wait = (bus.dma_req_i && !e_dg) ? dma_wait + 1 : 0;
    end

    @(posedge clk);
    #1;
  endtask

  task automatic core_set(input bit req, input logic [BK-1:0] we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.core_req_i   = req;
    bus.core_we_i    = we;
    bus.core_addr_i  = a;
    bus.core_wdata_i = d;
  endtask

  task automatic dma_set(input bit req, input logic [BK-1:0] we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.dma_req_i   = req;
    bus.dma_we_i    = we;
    bus.dma_addr_i  = a;
    bus.dma_wdata_i = d;
  endtask

  initial begin
    dma_wait = 0;
    pend_v   = 1'b0;
    pend_dma = 1'b0;
    pend_data = '0;

    // Reset with core requesting: no grants, core stalls.
    rst = 1'b1;
    core_set(1'b1, 4'b0000, 16'h0000, 32'h0);
    dma_set(1'b0, 4'b0000, 16'h0000, 32'h0);
    cycle();
    check("rst_core_gnt", 32'(obs_core_gnt), 32'd0);
    check("rst_stall", 32'(obs_stall), 32'd1);
    check("rst_en", 32'(obs_en), 32'd0);
    cycle();
    rst = 1'b0;
    core_set(1'b0, 4'b0000, 16'h0000, 32'h0);
    cycle();
    check("post_rst_state", 32'(dut.state_q), 32'(CORE_PRI));

    // Preload through the core port.
    core_set(1'b1, 4'b1111, 16'h0010, 32'hDEADBEEF);
    cycle();
    core_set(1'b1, 4'b1111, 16'h0004, 32'h11112222);
    cycle();
    core_set(1'b1, 4'b1111, 16'h0008, 32'h33334444);
    cycle();

    // Core read of 0x0010.
    core_set(1'b1, 4'b0000, 16'h0010, 32'h0);
    cycle();
    check("cread_gnt", 32'(obs_core_gnt), 32'd1);
    core_set(1'b0, 4'b0000, 16'h0000, 32'h0);
    cycle();
    check("cread_rvalid", 32'(obs_core_rv), 32'd1);
    check("cread_rdata", obs_core_rd, 32'hDEADBEEF);
    check("cread_dma_rvalid", 32'(obs_dma_rv), 32'd0);

    // Starvation: core held, DMA write waits 4 cycles then is forced.
    core_set(1'b1, 4'b0000, 16'h0000, 32'h0);
    dma_set(1'b1, 4'b1111, 16'h0020, 32'hCAFEF00D);
    for (int i = 0; i < STARVE_MAX; i++) begin
      cycle();
      check("starve_core_gnt", 32'(obs_core_gnt), 32'd1);
    end
    cycle();
    check("forced_dma_gnt", 32'(obs_dma_gnt), 32'd1);
    check("forced_en", 32'(obs_en), 32'hF);
    check("forced_stall", 32'(obs_stall), 32'd1);
    dma_set(1'b0, 4'b0000, 16'h0000, 32'h0);
    cycle();
    check("after_force_core_gnt", 32'(obs_core_gnt), 32'd1);

    // Interleaved reads: core 0x0004 then DMA 0x0008.
    core_set(1'b1, 4'b0000, 16'h0004, 32'h0);
    cycle();
    core_set(1'b0, 4'b0000, 16'h0000, 32'h0);
    dma_set(1'b1, 4'b0000, 16'h0008, 32'h0);
    cycle();
    check("il_core_rvalid", 32'(obs_core_rv), 32'd1);
    check("il_core_rdata", obs_core_rd, 32'h11112222);
    dma_set(1'b0, 4'b0000, 16'h0000, 32'h0);
    cycle();
    check("il_dma_rvalid", 32'(obs_dma_rv), 32'd1);
    check("il_dma_rdata", obs_dma_rd, 32'h33334444);
    check("il_core_rvalid_off", 32'(obs_core_rv), 32'd0);

    // Byte store with DMA idle.
    core_set(1'b1, 4'b0001, 16'h0030, 32'h000000AB);
    cycle();
    check("bstore_en", 32'(obs_en), 32'h1);
    core_set(1'b0, 4'b0000, 16'h0000, 32'h0);
    cycle();
    check("bstore_no_rvalid", 32'(obs_core_rv | obs_dma_rv), 32'd0);
    check("bstore_starve_cnt", 32'(dut.starve_cnt_q), 32'd0);

    // Reset in the cycle after a granted core read.
    core_set(1'b1, 4'b0000, 16'h0010, 32'h0);
    cycle();
    core_set(1'b0, 4'b0000, 16'h0000, 32'h0);
    rst = 1'b1;
    cycle();
    check("rstrd_rvalid", 32'(obs_core_rv), 32'd0);
    rst = 1'b0;
    cycle();
    check("rstrd_rvalid_after", 32'(obs_core_rv), 32'd0);

    // Randomised traffic; a DMA request is held until the model grants it.
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      core_set($urandom_range(0, 9) < 6,
               ($urandom_range(0, 1) == 0) ? 4'b0000 : BK'($urandom),
               AW'($urandom_range(0, 15) << 2), $urandom);
      if (!bus.dma_req_i && $urandom_range(0, 9) < 5) begin
        dma_set(1'b1, ($urandom_range(0, 1) == 0) ? 4'b0000 : BK'($urandom),
                AW'($urandom_range(0, 15) << 2), $urandom);
      end
      cycle();
      if (e_dma_gnt_last) bus.dma_req_i = 1'b0;
    end

    rst = 1'b0;
    core_set(1'b0, 4'b0000, 16'h0000, 32'h0);
    dma_set(1'b0, 4'b0000, 16'h0000, 32'h0);
    cycle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
